// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard: two read ports, one write port, optional bypass.
// Reads are combinational, or registered with one cycle of latency when REG_READ=1. There are no stalls.
module regfile_sb #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 3,
  parameter int BYPASS    = 1,
  parameter int REG_READ  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_BITS-1:0]    rd0_addr,
  output logic [WIDTH-1:0]        rd0_data,
  output logic                    rd0_busy,
  input  logic [ADDR_BITS-1:0]    rd1_addr,
  output logic [WIDTH-1:0]        rd1_data,
  output logic                    rd1_busy,
  input  logic                    wr_en,
  input  logic [ADDR_BITS-1:0]    wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rsv_en,
  input  logic [ADDR_BITS-1:0]    rsv_addr,
  output logic [2**ADDR_BITS-1:0] busy
);

  localparam int DEPTH = 2**ADDR_BITS;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] sb;
  logic [DEPTH-1:0] sb_nxt;
  logic [WIDTH-1:0] rd0_d;
  logic [WIDTH-1:0] rd1_d;
  logic             rd0_b;
  logic             rd1_b;

  // Reservation is applied after the writeback clear so that it wins on a same-address collision.
  always_comb begin
    sb_nxt = sb;
    if (wr_en) sb_nxt[wr_addr] = 1'b0;
    if (rsv_en) sb_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '{default: '0};
      sb  <= '0;
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      sb <= sb_nxt;
    end
  end

  // Bypass is gated by rst_n so that reset always wins over a concurrent write.
  always_comb begin
    rd0_d = mem[rd0_addr];
    rd0_b = sb[rd0_addr];
    rd1_d = mem[rd1_addr];
    rd1_b = sb[rd1_addr];
    if (BYPASS != 0 && rst_n && wr_en) begin
      if (rd0_addr == wr_addr) begin
        rd0_d = wr_data;
        rd0_b = sb_nxt[rd0_addr];
      end
      if (rd1_addr == wr_addr) begin
        rd1_d = wr_data;
        rd1_b = sb_nxt[rd1_addr];
      end
    end
  end

  generate
    if (REG_READ != 0) begin : g_reg_read
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd0_data <= '0;
          rd0_busy <= 1'b0;
          rd1_data <= '0;
          rd1_busy <= 1'b0;
        end else begin
          rd0_data <= rd0_d;
          rd0_busy <= rd0_b;
          rd1_data <= rd1_d;
          rd1_busy <= rd1_b;
        end
      end
    end else begin : g_comb_read
      assign rd0_data = rd0_d;
      assign rd0_busy = rd0_b;
      assign rd1_data = rd1_d;
      assign rd1_busy = rd1_b;
    end
  endgenerate

  assign busy = sb;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: bypass, no-bypass, registered-read and 32x16 instances.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  rd0_addr = '0, rd1_addr = '0, wr_addr = '0, rsv_addr = '0;
  logic        wr_en = 1'b0, rsv_en = 1'b0;
  logic [15:0] wr_data = '0;

  logic [15:0] a_rd0_data, a_rd1_data, b_rd0_data, b_rd1_data, c_rd0_data, c_rd1_data;
  logic        a_rd0_busy, a_rd1_busy, b_rd0_busy, b_rd1_busy, c_rd0_busy, c_rd1_busy;
  logic [7:0]  a_busy, b_busy, c_busy;

  logic [3:0]  d_rd0_addr = '0, d_rd1_addr = '0, d_wr_addr = '0, d_rsv_addr = '0;
  logic        d_wr_en = 1'b0, d_rsv_en = 1'b0;
  logic [31:0] d_wr_data = '0;
  logic [31:0] d_rd0_data, d_rd1_data;
  logic        d_rd0_busy, d_rd1_busy;
  logic [15:0] d_busy;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_sb #(.WIDTH(16), .ADDR_BITS(3), .BYPASS(1), .REG_READ(0)) u_a (
    .clk(clk), .rst_n(rst_n),
    .rd0_addr(rd0_addr), .rd0_data(a_rd0_data), .rd0_busy(a_rd0_busy),
    .rd1_addr(rd1_addr), .rd1_data(a_rd1_data), .rd1_busy(a_rd1_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(a_busy));

  regfile_sb #(.WIDTH(16), .ADDR_BITS(3), .BYPASS(0), .REG_READ(0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .rd0_addr(rd0_addr), .rd0_data(b_rd0_data), .rd0_busy(b_rd0_busy),
    .rd1_addr(rd1_addr), .rd1_data(b_rd1_data), .rd1_busy(b_rd1_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(b_busy));

  regfile_sb #(.WIDTH(16), .ADDR_BITS(3), .BYPASS(1), .REG_READ(1)) u_c (
    .clk(clk), .rst_n(rst_n),
    .rd0_addr(rd0_addr), .rd0_data(c_rd0_data), .rd0_busy(c_rd0_busy),
    .rd1_addr(rd1_addr), .rd1_data(c_rd1_data), .rd1_busy(c_rd1_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(c_busy));

  regfile_sb #(.WIDTH(32), .ADDR_BITS(4), .BYPASS(1), .REG_READ(0)) u_d (
    .clk(clk), .rst_n(rst_n),
    .rd0_addr(d_rd0_addr), .rd0_data(d_rd0_data), .rd0_busy(d_rd0_busy),
    .rd1_addr(d_rd1_addr), .rd1_data(d_rd1_data), .rd1_busy(d_rd1_busy),
    .wr_en(d_wr_en), .wr_addr(d_wr_addr), .wr_data(d_wr_data),
    .rsv_en(d_rsv_en), .rsv_addr(d_rsv_addr), .busy(d_busy));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    step();
    chk("rst_a_busy", 64'(a_busy), 64'h00);
    chk("rst_a_rd0", 64'(a_rd0_data), 64'h0);
    chk("rst_c_rd0", 64'(c_rd0_data), 64'h0);
    chk("rst_c_rd0_busy", 64'(c_rd0_busy), 64'h0);
    chk("rst_d_busy", 64'(d_busy), 64'h0);

    // Write R3 while reading it, then reset mid-cycle
    rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF; rd0_addr = 3'd3;
    #1;
    chk("byp_a_r3", 64'(a_rd0_data), 64'hBEEF);
    chk("nobyp_b_r3", 64'(b_rd0_data), 64'h0);
    step();
    wr_en = 1'b0;
    chk("stored_b_r3", 64'(b_rd0_data), 64'hBEEF);
    chk("regrd_c_r3", 64'(c_rd0_data), 64'hBEEF);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_a_r3", 64'(a_rd0_data), 64'h0);
    chk("midrst_a_busy", 64'(a_busy), 64'h0);
    chk("midrst_c_r3", 64'(c_rd0_data), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234; rd0_addr = 3'd5;
    step();
    wr_en = 1'b0;
    chk("post_rst_b_r5", 64'(b_rd0_data), 64'h1234);
    chk("post_rst_c_r5", 64'(c_rd0_data), 64'h1234);

    // Scoreboard: reserve R2, then write it back
    rsv_en = 1'b1; rsv_addr = 3'd2; rd0_addr = 3'd2;
    #1;
    chk("rsv_pre_busy", 64'(a_busy), 64'h00);
    step();
    rsv_en = 1'b0;
    chk("rsv_busy_vec", 64'(a_busy), 64'h04);
    chk("rsv_rd0_busy", 64'(a_rd0_busy), 64'h1);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h00AA;
    #1;
    chk("wb_byp_busy", 64'(a_rd0_busy), 64'h0);
    chk("wb_nobyp_busy", 64'(b_rd0_busy), 64'h1);
    step();
    wr_en = 1'b0;
    chk("wb_busy_vec", 64'(a_busy), 64'h00);
    chk("wb_rd0_data", 64'(a_rd0_data), 64'h00AA);
    chk("wb_c_busy", 64'(c_rd0_busy), 64'h0);
    chk("wb_c_data", 64'(c_rd0_data), 64'h00AA);

    // Same-address write + reserve: reservation wins
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h5555;
    rsv_en = 1'b1; rsv_addr = 3'd4; rd1_addr = 3'd4;
    #1;
    chk("coll_byp_busy", 64'(a_rd1_busy), 64'h1);
    step();
    wr_en = 1'b0; rsv_en = 1'b0;
    chk("coll_busy_vec", 64'(a_busy), 64'h10);
    chk("coll_r4", 64'(a_rd1_data), 64'h5555);
    chk("coll_b_rd1_busy", 64'(b_rd1_busy), 64'h1);

    // Write R4 and reserve R1 in the same cycle
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h6666;
    rsv_en = 1'b1; rsv_addr = 3'd1;
    step();
    wr_en = 1'b0; rsv_en = 1'b0;
    chk("diff_busy_vec", 64'(b_busy), 64'h02);
    chk("diff_r4", 64'(b_rd1_data), 64'h6666);
    chk("diff_c_busy_vec", 64'(c_busy), 64'h02);

    // Bypass on both ports
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h1111;
    step();
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h2222; rd0_addr = 3'd1; rd1_addr = 3'd1;
    #1;
    chk("byp_a_rd0", 64'(a_rd0_data), 64'h2222);
    chk("byp_a_rd1", 64'(a_rd1_data), 64'h2222);
    chk("nobyp_b_rd0", 64'(b_rd0_data), 64'h1111);
    chk("nobyp_b_rd1", 64'(b_rd1_data), 64'h1111);
    chk("byp_a_busy_vec", 64'(a_busy), 64'h00);
    step();
    wr_en = 1'b0;

    // Registered read: one cycle latency, holds across mid-cycle address change
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h0F0F;
    step();
    wr_en = 1'b0; rd1_addr = 3'd6;
    step();
    chk("regrd_r6", 64'(c_rd1_data), 64'h0F0F);
    chk("regrd_r6_busy", 64'(c_rd1_busy), 64'h0);
    #2 rd1_addr = 3'd0;
    #1;
    chk("regrd_hold", 64'(c_rd1_data), 64'h0F0F);
    chk("comb_r0", 64'(a_rd1_data), 64'h0);

    // Wide instance
    step();
    d_wr_en = 1'b1; d_wr_addr = 4'd15; d_wr_data = 32'hDEADBEEF;
    step();
    d_wr_en = 1'b0; d_rd0_addr = 4'd15; d_rd1_addr = 4'd15;
    #1;
    chk("wide_rd0", 64'(d_rd0_data), 64'hDEADBEEF);
    chk("wide_rd1", 64'(d_rd1_data), 64'hDEADBEEF);
    chk("wide_busy_pre", 64'(d_busy), 64'h0);
    d_rsv_en = 1'b1; d_rsv_addr = 4'd15;
    step();
    d_rsv_en = 1'b0;
    chk("wide_busy_vec", 64'(d_busy), 64'h8000);
    chk("wide_rd0_busy", 64'(d_rd0_busy), 64'h1);
    chk("wide_rd1_busy", 64'(d_rd1_busy), 64'h1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with scoreboard for the LC-3 datapath and its wider derivatives. It provides two independent read ports, one write port with optional same-cycle write-to-read bypass, and an optional registered-read mode. A per-register busy bit lets the control unit reserve a destination at issue and clear it at writeback. The block sits between the decode/control FSM, which drives addresses and reservations, and the bus, which supplies writeback data.

## Interface
Parameters:
- WIDTH, 16, data width of each register
- ADDR_BITS, 3, register address width; depth DEPTH = 2**ADDR_BITS
- BYPASS, 1, 1 = a same-cycle write is visible on read ports; 0 = reads return the stored value only
- REG_READ, 0, 0 = combinational read data; 1 = read data and busy registered, 1-cycle latency

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rd0_addr  in  ADDR_BITS  read port 0 address (SR1)
- rd0_data  out  WIDTH  read port 0 data
- rd0_busy  out  1  busy bit of rd0_addr
- rd1_addr  in  ADDR_BITS  read port 1 address (SR2)
- rd1_data  out  WIDTH  read port 1 data
- rd1_busy  out  1  busy bit of rd1_addr
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_BITS  write address (DR)
- wr_data  in  WIDTH  write data from bus
- rsv_en  in  1  reserve strobe: mark rsv_addr busy
- rsv_addr  in  ADDR_BITS  register to reserve
- busy  out  DEPTH  full scoreboard vector, bit i = register i busy

## Operation
- Storage: DEPTH x WIDTH registers, written on rising clk when wr_en=1; wr_addr selects the register.
- Scoreboard: busy[i] set on the clock edge with rsv_en=1 and rsv_addr=i; cleared on the edge with wr_en=1 and wr_addr=i, unless that rule is overridden below.
- Simultaneous wr_en and rsv_en to the same address: data is written and busy stays/becomes 1 (reservation wins; a new producer is in flight).
- Simultaneous wr_en and rsv_en to different addresses: both take effect independently.
- A write to a non-busy register is legal: data is written and busy stays 0.
- A reserve of an already-busy register is legal: busy stays 1.
- Read, BYPASS=1: if wr_en=1 and rdN_addr==wr_addr, rdN_data = wr_data and rdN_busy reflects the post-edge busy value (0 unless rsv_en also targets that address). Otherwise rdN_data is the stored register and rdN_busy = busy[rdN_addr].
- Read, BYPASS=0: rdN_data is the stored register and rdN_busy = busy[rdN_addr]. The current cycle's write is not seen.
- Both read ports may address the same register and must return identical values.
- REG_READ=1: the values described above are captured on the rising edge and presented one cycle later. The outputs hold between edges.
- Arithmetic: none. No width conversion. Addresses are always in range by construction.

## Timing
- Reset (rst_n=0, asynchronous): all registers = 0, busy = 0. With REG_READ=1, rd0_data/rd1_data = 0 and rd0_busy/rd1_busy = 0. With REG_READ=0, outputs reflect the zeroed storage immediately.
- Reset asserted mid-operation overrides any concurrent write or reserve. Release is synchronous to the next clk edge; the first write is accepted on the first edge with rst_n=1.
- Write latency: the stored value is visible on the cycle after the write edge. With BYPASS=1 it is also visible in the write cycle itself (REG_READ=0) or on the next cycle (REG_READ=1, write-first capture).
- Busy latency: busy changes on the edge after rsv_en/wr_en is sampled. The `busy` vector is always the stored scoreboard and is never bypassed.
- No handshake stalls: every strobe is accepted on the edge on which it is sampled.

## Test plan
- Reset: write 0xBEEF to R3, then assert rst_n=0 mid-cycle -> R3 reads 0x0000 and busy=0 immediately. Then release, write 0x1234 to R5, read R5 next cycle -> 0x1234.
- Scoreboard: rsv R2 -> busy=0x04 and rd0_busy=1 for addr 2. Next, write R2=0x00AA -> busy=0x00, rd0_data=0x00AA.
- Same-address collision: wr R4=0x5555 and rsv R4 in the same cycle -> R4=0x5555 and busy[4]=1 afterwards.
- Bypass (BYPASS=1, REG_READ=0): R1=0x1111 stored; write R1=0x2222 while rd0_addr=rd1_addr=1 -> both ports show 0x2222 in that cycle. With BYPASS=0 both show 0x1111.
- Registered read (REG_READ=1): set rd1_addr=6 with R6=0x0F0F -> rd1_data=0x0F0F one cycle later and holds while the address changes mid-cycle.
- Parametrisation: WIDTH=32, ADDR_BITS=4 -> write 0xDEADBEEF to R15 and read it back; rsv R15 sets busy bit 15 only.
